// File: rtl/cve2_mac_sequencer.sv
// cve2_mac_sequencer
//   Multi-cycle multiply-accumulate sequencer for the execute stage. Accepts
//   MAC / MSU / CLR / READ requests, drives the shared multiplier through a
//   req/valid handshake and accumulates into a bank of NumAcc registers with
//   either wrap-around or signed-saturating arithmetic.
//
// Parameters
//   Width    operand / product / accumulator width
//   NumAcc   number of accumulators (power of two, >= 2)
//   Saturate 0: modular accumulate, 1: signed saturating accumulate
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i, ready_o           request handshake (ready only in IDLE)
//   op_i                     00 MAC, 01 MSU, 10 CLR, 11 READ
//   acc_sel_i                target accumulator
//   op_a_i, op_b_i           signed multiplier operands
//   kill_i                   flush: aborts any in-flight operation
//   mul_req_o                request to the shared multiplier
//   mul_op_a_o, mul_op_b_o   latched operands for the multiplier
//   mul_valid_i              multiplier result valid
//   mul_result_i             low Width bits of the product
//   result_valid_o           one-cycle result strobe
//   result_o, ovf_o          accumulator value / signed overflow flag
//   busy_o                   high whenever not IDLE
module cve2_mac_sequencer #(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumAcc   = 4,
  parameter bit          Saturate = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      ready_o,
  input  logic [1:0]                op_i,
  input  logic [$clog2(NumAcc)-1:0] acc_sel_i,
  input  logic [Width-1:0]          op_a_i,
  input  logic [Width-1:0]          op_b_i,
  input  logic                      kill_i,
  output logic                      mul_req_o,
  output logic [Width-1:0]          mul_op_a_o,
  output logic [Width-1:0]          mul_op_b_o,
  input  logic                      mul_valid_i,
  input  logic [Width-1:0]          mul_result_i,
  output logic                      result_valid_o,
  output logic [Width-1:0]          result_o,
  output logic                      ovf_o,
  output logic                      busy_o
);

  localparam int unsigned SelW = $clog2(NumAcc);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_MSU  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  state_e           state;
  op_e              op;
  logic [SelW-1:0]  sel;
  logic [Width-1:0] product;
  logic [Width-1:0] acc [NumAcc];

  logic [Width-1:0] acc_cur;
  logic [Width:0]   sum;
  logic             sum_ovf;
  logic [Width-1:0] acc_next;

  // Sign-extend to Width+1 bits so overflow is visible as the top two bits
  // disagreeing.
  always_comb begin
    acc_cur = acc[sel];
    if (op == OP_MSU) begin
      sum = {acc_cur[Width-1], acc_cur} - {product[Width-1], product};
    end else begin
      sum = {acc_cur[Width-1], acc_cur} + {product[Width-1], product};
    end
    sum_ovf  = sum[Width] ^ sum[Width-1];
    acc_next = sum[Width-1:0];
    if (Saturate && sum_ovf) begin
      acc_next = sum[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
  end

  // result_o / ovf_o are loaded on the edge that enters RESP, so they are
  // valid during RESP and simply hold afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      op         <= OP_MAC;
      sel        <= '0;
      product    <= '0;
      mul_op_a_o <= '0;
      mul_op_b_o <= '0;
      result_o   <= '0;
      ovf_o      <= 1'b0;
      acc        <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i && !kill_i) begin
            op         <= op_e'(op_i);
            sel        <= acc_sel_i;
            mul_op_a_o <= op_a_i;
            mul_op_b_o <= op_b_i;
            case (op_e'(op_i))
              OP_CLR: begin
                acc[acc_sel_i] <= '0;
                result_o       <= '0;
                ovf_o          <= 1'b0;
                state          <= S_RESP;
              end
              OP_READ: begin
                result_o <= acc[acc_sel_i];
                ovf_o    <= 1'b0;
                state    <= S_RESP;
              end
              default: state <= S_MUL;
            endcase
          end
        end
        S_MUL: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else if (mul_valid_i) begin
            product <= mul_result_i;
            state   <= S_ACC;
          end
        end
        S_ACC: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else begin
            acc[sel] <= acc_next;
            result_o <= acc_next;
            ovf_o    <= sum_ovf;
            state    <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o        = (state == S_IDLE);
  assign busy_o         = (state != S_IDLE);
  assign mul_req_o      = (state == S_MUL);
  assign result_valid_o = (state == S_RESP) && !kill_i;

endmodule

// File: tb/tb_cve2_mac_sequencer.sv
// Testbench for cve2_mac_sequencer: a wrap-mode and a saturate-mode instance
// share all inputs; the bench plays the multiplier and keeps its own
// accumulator model for each instance.
module tb_cve2_mac_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic req_i = 1'b0, kill_i = 1'b0, mul_valid_i = 1'b0;
  logic [1:0] op_i = '0, acc_sel_i = '0;
  logic [W-1:0] op_a_i = '0, op_b_i = '0, mul_result_i = '0;

  logic ready_w, mreq_w, rv_w, ovf_w, busy_w;
  logic [W-1:0] ma_w, mb_w, res_w;
  logic ready_s, mreq_s, rv_s, ovf_s, busy_s;
  logic [W-1:0] ma_s, mb_s, res_s;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl_w [4];
  logic [W-1:0] mdl_s [4];

  // observations from the most recent run_op
  int obs_vc_w, obs_vc_s, obs_nv, obs_rdy, obs_mreq, obs_opbad, obs_decbad;
  logic [W-1:0] obs_res_w, obs_res_s;
  logic obs_ovf_w, obs_ovf_s;

  always #5 clk = ~clk;

  cve2_mac_sequencer #(.Width(W), .NumAcc(4), .Saturate(1'b0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .ready_o(ready_w), .op_i(op_i),
    .acc_sel_i(acc_sel_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .mul_req_o(mreq_w), .mul_op_a_o(ma_w), .mul_op_b_o(mb_w), .mul_valid_i(mul_valid_i),
    .mul_result_i(mul_result_i), .result_valid_o(rv_w), .result_o(res_w), .ovf_o(ovf_w),
    .busy_o(busy_w)
  );

  cve2_mac_sequencer #(.Width(W), .NumAcc(4), .Saturate(1'b1)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .ready_o(ready_s), .op_i(op_i),
    .acc_sel_i(acc_sel_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .mul_req_o(mreq_s), .mul_op_a_o(ma_s), .mul_op_b_o(mb_s), .mul_valid_i(mul_valid_i),
    .mul_result_i(mul_result_i), .result_valid_o(rv_s), .result_o(res_s), .ovf_o(ovf_s),
    .busy_o(busy_s)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] prod_of(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[W-1:0];
  endfunction

  function automatic logic [W:0] acc_of(input logic [W-1:0] acc, input logic [W-1:0] p,
                                        input bit sub, input bit sat);
    longint s;
    logic [W-1:0] v;
    logic o;
    s = sub ? longint'($signed(acc)) - longint'($signed(p))
            : longint'($signed(acc)) + longint'($signed(p));
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    v = s[W-1:0];
    if (sat && o) v = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
    return {o, v};
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [1:0] sel,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] ew, output logic [W-1:0] es,
                          output logic ow, output logic os);
    logic [W:0] rw, rs;
    case (op)
      2'b10: begin
        mdl_w[sel] = '0; mdl_s[sel] = '0;
        ew = '0; es = '0; ow = 1'b0; os = 1'b0;
      end
      2'b11: begin
        ew = mdl_w[sel]; es = mdl_s[sel]; ow = 1'b0; os = 1'b0;
      end
      default: begin
        rw = acc_of(mdl_w[sel], prod_of(a, b), op[0], 1'b0);
        rs = acc_of(mdl_s[sel], prod_of(a, b), op[0], 1'b1);
        mdl_w[sel] = rw[W-1:0]; mdl_s[sel] = rs[W-1:0];
        ew = rw[W-1:0]; es = rs[W-1:0]; ow = rw[W]; os = rs[W];
      end
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mdl_w[i] = '0;
      mdl_s[i] = '0;
    end
  endtask

  // ---------------- stimulus driver ----------------
  // Cycle 0 is the current window (just after a rising edge). Returns in the
  // first window where ready_o is back (and any late multiplier response has
  // been driven), so a following call issues its request back-to-back.
  task automatic run_op(input logic [1:0] op, input logic [1:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int kill_c, input bit noise);
    bit is_mul;
    logic [W-1:0] p;
    is_mul = !op[1];
    p = prod_of(a, b);
    obs_vc_w = -1; obs_vc_s = -1; obs_nv = 0; obs_rdy = -1;
    obs_mreq = 0; obs_opbad = 0; obs_decbad = 0;
    obs_res_w = 'x; obs_res_s = 'x; obs_ovf_w = 1'bx; obs_ovf_s = 1'bx;
    req_i = 1'b1; op_i = op; acc_sel_i = sel; op_a_i = a; op_b_i = b;
    kill_i = 1'b0; mul_valid_i = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      kill_i = (c == kill_c);
      mul_valid_i = is_mul && (c == 1 + lat);
      mul_result_i = mul_valid_i ? p : $urandom();
      if (noise && kill_c == 0 && c <= 1 + lat) begin
        req_i = 1'($urandom_range(0, 1));
        op_i = 2'($urandom_range(0, 3));
        acc_sel_i = 2'($urandom_range(0, 3));
        op_a_i = $urandom();
        op_b_i = $urandom();
      end else begin
        req_i = 1'b0;
      end
      #1;
      if (busy_w === ready_w || busy_s === ready_s || ready_w !== ready_s || mreq_w !== mreq_s)
        obs_decbad++;
      if (mreq_w === 1'b1) begin
        obs_mreq++;
        if ({ma_w, mb_w, ma_s, mb_s} !== {a, b, a, b}) obs_opbad++;
      end
      if (rv_w === 1'b1 || rv_s === 1'b1) obs_nv++;
      if (rv_w === 1'b1 && obs_vc_w < 0) begin
        obs_vc_w = c; obs_res_w = res_w; obs_ovf_w = ovf_w;
      end
      if (rv_s === 1'b1 && obs_vc_s < 0) begin
        obs_vc_s = c; obs_res_s = res_s; obs_ovf_s = ovf_s;
      end
      if (ready_w === 1'b1 && obs_rdy < 0) obs_rdy = c;
      if (obs_rdy >= 0 && c >= 2 + lat) break;
      @(posedge clk); #1;
    end
    kill_i = 1'b0; mul_valid_i = 1'b0; req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready_w, ready_s, busy_w, busy_s, mreq_w, mreq_s, rv_w, rv_s} !== 8'b11000000) begin
        errors++;
        $display("FAIL reset_ctrl: got rdy/busy/mreq/rv=%b want 11000000",
                 {ready_w, ready_s, busy_w, busy_s, mreq_w, mreq_s, rv_w, rv_s});
      end
    end
    checks++;
    if ({res_w, res_s, ovf_w, ovf_s, ma_w, mb_w, ma_s, mb_s} !== '0) begin
      errors++;
      $display("FAIL reset_data: got res=%h/%h ovf=%b/%b mul_op=%h/%h/%h/%h want all 0",
               res_w, res_s, ovf_w, ovf_s, ma_w, mb_w, ma_s, mb_s);
    end
    rst_ni = 1'b1;
    clear_model();
    run_op(2'b11, 2'd2, '0, '0, 0, 0, 1'b0);
    checks++;
    if ({obs_vc_w, obs_vc_s, obs_rdy} !== {32'd1, 32'd1, 32'd2} ||
        {obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !== '0) begin
      errors++;
      $display("FAIL reset_read: got vc=%0d/%0d rdy=%0d res=%h/%h ovf=%b/%b want vc=1 rdy=2 res=0 ovf=0",
               obs_vc_w, obs_vc_s, obs_rdy, obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s);
    end
  endtask

  task automatic test_mac_basic();
    logic [W-1:0] ew, es;
    logic ow, os;
    run_op(2'b00, 2'd1, 32'd3, 32'd5, 0, 0, 1'b0);
    model_op(2'b00, 2'd1, 32'd3, 32'd5, ew, es, ow, os);
    checks++;
    if ({obs_vc_w, obs_vc_s, obs_rdy, obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !==
        {32'd3, 32'd3, 32'd4, 32'd15, 32'd15, 2'b00}) begin
      errors++;
      $display("FAIL mac_3x5: got vc=%0d/%0d rdy=%0d res=%0d/%0d ovf=%b/%b want vc=3 rdy=4 res=15 ovf=0",
               obs_vc_w, obs_vc_s, obs_rdy, obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s);
    end
    run_op(2'b00, 2'd1, 32'hFFFF_FFFE, 32'd4, 0, 0, 1'b0);
    model_op(2'b00, 2'd1, 32'hFFFF_FFFE, 32'd4, ew, es, ow, os);
    checks++;
    if ({obs_vc_w, obs_res_w, obs_res_s, obs_ovf_w} !== {32'd3, 32'd7, 32'd7, 1'b0}) begin
      errors++;
      $display("FAIL mac_m2x4: got vc=%0d res=%0d/%0d ovf=%b want vc=3 res=7/7 ovf=0",
               obs_vc_w, obs_res_w, obs_res_s, obs_ovf_w);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      run_op(2'b11, 2'(i), '0, '0, 0, 0, 1'b0);
      model_op(2'b11, 2'(i), '0, '0, ew, es, ow, os);
      checks++;
      if ({obs_res_w, obs_res_s} !== {ew, es}) begin
        errors++;
        $display("FAIL mac_others_acc%0d: got %h/%h want %h/%h", i, obs_res_w, obs_res_s, ew, es);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] ew, es;
    logic ow, os;
    req_i = 1'b1; op_i = 2'b00; acc_sel_i = 2'd1; op_a_i = 32'd9; op_b_i = 32'd9;
    @(posedge clk); #1;
    req_i = 1'b0;
    #1;
    checks++;
    if ({mreq_w, mreq_s} !== 2'b11) begin
      errors++;
      $display("FAIL midop_mreq: got %b want 11", {mreq_w, mreq_s});
    end
    #2 rst_ni = 1'b0;
    #1;
    clear_model();
    checks++;
    if ({busy_w, busy_s, mreq_w, mreq_s, ready_w, ready_s, rv_w, rv_s} !== 8'b00001100 ||
        {res_w, res_s, ovf_w, ovf_s, ma_w, mb_s} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got busy/mreq/rdy/rv=%b res=%h/%h ovf=%b/%b mul_op=%h/%h want 00001100 and zeros",
               {busy_w, busy_s, mreq_w, mreq_s, ready_w, ready_s, rv_w, rv_s},
               res_w, res_s, ovf_w, ovf_s, ma_w, mb_s);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    run_op(2'b11, 2'd1, '0, '0, 0, 0, 1'b0);
    model_op(2'b11, 2'd1, '0, '0, ew, es, ow, os);
    checks++;
    if ({obs_vc_w, obs_res_w, obs_res_s} !== {32'd1, ew, es}) begin
      errors++;
      $display("FAIL midop_acc1: got vc=%0d res=%h/%h want vc=1 res=%h/%h",
               obs_vc_w, obs_res_w, obs_res_s, ew, es);
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] a, b, ew, es;
    logic ow, os;
    a = $urandom_range(0, 1000);
    b = $urandom_range(0, 1000) - 500;
    run_op(2'b00, 2'd2, a, b, 4, 0, 1'b1);
    model_op(2'b00, 2'd2, a, b, ew, es, ow, os);
    checks++;
    if ({obs_mreq, obs_opbad, obs_decbad} !== {32'd5, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL lat4_handshake: got mreq_cycles=%0d op_unstable=%0d decode_bad=%0d want 5/0/0",
               obs_mreq, obs_opbad, obs_decbad);
    end
    checks++;
    if ({obs_vc_w, obs_vc_s, obs_rdy, obs_nv} !== {32'd7, 32'd7, 32'd8, 32'd1} ||
        {obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !== {ew, es, ow, os}) begin
      errors++;
      $display("FAIL lat4_result: got vc=%0d/%0d rdy=%0d n=%0d res=%h/%h ovf=%b/%b want vc=7 rdy=8 n=1 res=%h/%h ovf=%b/%b",
               obs_vc_w, obs_vc_s, obs_rdy, obs_nv, obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s,
               ew, es, ow, os);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ew, es;
    logic ow, os;
    run_op(2'b10, 2'd0, '0, '0, 0, 0, 1'b0);
    model_op(2'b10, 2'd0, '0, '0, ew, es, ow, os);
    run_op(2'b00, 2'd0, 32'h7FFF_FFF0, 32'd1, 1, 0, 1'b0);
    model_op(2'b00, 2'd0, 32'h7FFF_FFF0, 32'd1, ew, es, ow, os);
    checks++;
    if ({obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !== {32'h7FFF_FFF0, 32'h7FFF_FFF0, 2'b00}) begin
      errors++;
      $display("FAIL ovf_preload: got %h/%h ovf=%b/%b want 7ffffff0 ovf=0",
               obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s);
    end
    run_op(2'b00, 2'd0, 32'h20, 32'd1, 0, 0, 1'b0);
    model_op(2'b00, 2'd0, 32'h20, 32'd1, ew, es, ow, os);
    checks++;
    if ({obs_res_w, obs_ovf_w, obs_res_s, obs_ovf_s} !== {32'h8000_0010, 1'b1, 32'h7FFF_FFFF, 1'b1}) begin
      errors++;
      $display("FAIL ovf_mac_pos: got wrap=%h/%b sat=%h/%b want wrap=80000010/1 sat=7fffffff/1",
               obs_res_w, obs_ovf_w, obs_res_s, obs_ovf_s);
    end
    run_op(2'b10, 2'd0, '0, '0, 0, 0, 1'b0);
    model_op(2'b10, 2'd0, '0, '0, ew, es, ow, os);
    run_op(2'b00, 2'd0, 32'h8000_0000, 32'd1, 0, 0, 1'b0);
    model_op(2'b00, 2'd0, 32'h8000_0000, 32'd1, ew, es, ow, os);
    run_op(2'b01, 2'd0, 32'd1, 32'd1, 2, 0, 1'b0);
    model_op(2'b01, 2'd0, 32'd1, 32'd1, ew, es, ow, os);
    checks++;
    if ({obs_res_w, obs_ovf_w, obs_res_s, obs_ovf_s} !== {32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1}) begin
      errors++;
      $display("FAIL ovf_msu_neg: got wrap=%h/%b sat=%h/%b want wrap=7fffffff/1 sat=80000000/1",
               obs_res_w, obs_ovf_w, obs_res_s, obs_ovf_s);
    end
    run_op(2'b11, 2'd0, '0, '0, 0, 0, 1'b0);
    model_op(2'b11, 2'd0, '0, '0, ew, es, ow, os);
    checks++;
    if ({obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !== {ew, es, 2'b00}) begin
      errors++;
      $display("FAIL ovf_read_clears_flag: got %h/%h ovf=%b/%b want %h/%h ovf=0",
               obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s, ew, es);
    end
  endtask

  task automatic test_kill();
    logic [W-1:0] ew, es, a;
    logic ow, os;
    int kc;
    a = $urandom_range(1, 5000);
    run_op(2'b00, 2'd2, a, 32'd1, 0, 0, 1'b0);
    model_op(2'b00, 2'd2, a, 32'd1, ew, es, ow, os);
    for (int k = 0; k < 3; k++) begin
      kc = (k == 0) ? 1 : (k == 1) ? 4 : 5;
      a = $urandom_range(1, 5000);
      run_op(2'b00, 2'd2, a, 32'd3, 2, kc, 1'b0);
      // A kill in RESP arrives after the accumulator write has committed.
      if (k == 2) model_op(2'b00, 2'd2, a, 32'd3, ew, es, ow, os);
      checks++;
      if ({obs_nv, obs_rdy, obs_mreq} !== {32'd0, 32'(kc + 1), ((k == 0) ? 32'd1 : 32'd3)}) begin
        errors++;
        $display("FAIL kill_stage%0d: got valids=%0d rdy=%0d mreq_cycles=%0d want 0/%0d/%0d",
                 k, obs_nv, obs_rdy, obs_mreq, kc + 1, (k == 0) ? 1 : 3);
      end
      run_op(2'b11, 2'd2, '0, '0, 0, 0, 1'b0);
      model_op(2'b11, 2'd2, '0, '0, ew, es, ow, os);
      checks++;
      if ({obs_res_w, obs_res_s} !== {ew, es}) begin
        errors++;
        $display("FAIL kill_stage%0d_acc: got %h/%h want %h/%h", k, obs_res_w, obs_res_s, ew, es);
      end
    end
    req_i = 1'b1; kill_i = 1'b1; op_i = 2'b00; acc_sel_i = 2'd0;
    @(posedge clk); #1;
    req_i = 1'b0; kill_i = 1'b0;
    #1;
    checks++;
    if ({busy_w, busy_s, ready_w, ready_s} !== 4'b0011) begin
      errors++;
      $display("FAIL kill_idle_blocks: got busy/ready=%b want 0011", {busy_w, busy_s, ready_w, ready_s});
    end
  endtask

  task automatic test_msu_clr();
    logic [W-1:0] ew, es;
    logic ow, os;
    run_op(2'b10, 2'd3, '0, '0, 0, 0, 1'b0);
    model_op(2'b10, 2'd3, '0, '0, ew, es, ow, os);
    run_op(2'b00, 2'd3, 32'd10, 32'd1, 1, 0, 1'b0);
    model_op(2'b00, 2'd3, 32'd10, 32'd1, ew, es, ow, os);
    run_op(2'b01, 2'd3, 32'd2, 32'd3, 0, 0, 1'b0);
    model_op(2'b01, 2'd3, 32'd2, 32'd3, ew, es, ow, os);
    checks++;
    if ({obs_vc_w, obs_res_w, obs_res_s, obs_ovf_w} !== {32'd3, 32'd4, 32'd4, 1'b0}) begin
      errors++;
      $display("FAIL msu_10m6: got vc=%0d res=%0d/%0d ovf=%b want vc=3 res=4 ovf=0",
               obs_vc_w, obs_res_w, obs_res_s, obs_ovf_w);
    end
    run_op(2'b10, 2'd3, '0, '0, 0, 0, 1'b0);
    model_op(2'b10, 2'd3, '0, '0, ew, es, ow, os);
    checks++;
    if ({obs_vc_w, obs_rdy, obs_res_w, obs_res_s} !== {32'd1, 32'd2, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL clr_acc3: got vc=%0d rdy=%0d res=%h/%h want vc=1 rdy=2 res=0",
               obs_vc_w, obs_rdy, obs_res_w, obs_res_s);
    end
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 2'(3 - i), '0, '0, 0, 0, 1'b0);
      model_op(2'b11, 2'(3 - i), '0, '0, ew, es, ow, os);
      checks++;
      if ({obs_res_w, obs_res_s} !== {ew, es}) begin
        errors++;
        $display("FAIL clr_read_acc%0d: got %h/%h want %h/%h", 3 - i, obs_res_w, obs_res_s, ew, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ew, es;
    logic ow, os;
    logic [1:0] ops [3];
    int lat;
    ops[0] = 2'b00; ops[1] = 2'b11; ops[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      lat = (ops[i][1]) ? 0 : int'($urandom_range(0, 2));
      run_op(ops[i], 2'd1, 32'd7, 32'd11, lat, 0, 1'b0);
      model_op(ops[i], 2'd1, 32'd7, 32'd11, ew, es, ow, os);
      checks++;
      if ({obs_vc_w, obs_rdy, obs_res_w, obs_res_s} !==
          {(ops[i][1] ? 32'd1 : 32'(3 + lat)), (ops[i][1] ? 32'd2 : 32'(4 + lat)), ew, es}) begin
        errors++;
        $display("FAIL b2b_%0d: got vc=%0d rdy=%0d res=%h/%h want res=%h/%h (lat %0d)",
                 i, obs_vc_w, obs_rdy, obs_res_w, obs_res_s, ew, es, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, ew, es;
    logic ow, os;
    logic [1:0] op, sel;
    int lat, exp_vc;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      if (i % 2 == 0) begin
        a = $urandom(); b = $urandom();
      end else begin
        a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 200) - 100;
      end
      lat = op[1] ? 0 : int'($urandom_range(0, 3));
      run_op(op, sel, a, b, lat, 0, 1'($urandom_range(0, 1)));
      model_op(op, sel, a, b, ew, es, ow, os);
      exp_vc = op[1] ? 1 : 3 + lat;
      checks++;
      if ({obs_vc_w, obs_vc_s, obs_rdy, obs_nv, obs_opbad, obs_decbad} !==
          {32'(exp_vc), 32'(exp_vc), 32'(exp_vc + 1), 32'd1, 32'd0, 32'd0} ||
          {obs_res_w, obs_res_s, obs_ovf_w, obs_ovf_s} !== {ew, es, ow, os}) begin
        errors++;
        $display("FAIL rand_%0d op=%0d sel=%0d: got vc=%0d/%0d rdy=%0d n=%0d res=%h/%h ovf=%b/%b want vc=%0d res=%h/%h ovf=%b/%b",
                 i, op, sel, obs_vc_w, obs_vc_s, obs_rdy, obs_nv, obs_res_w, obs_res_s,
                 obs_ovf_w, obs_ovf_s, exp_vc, ew, es, ow, os);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mac_basic();
    test_reset_midop();
    test_latency();
    test_overflow();
    test_kill();
    test_msu_clr();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
